vending_machine: RTL and testbench

//  Coin-operated vend controller. Accumulates credit from single-line coin

---
 rtl/vending_machine_pkg.sv | 15 +
 rtl/vending_machine.sv | 61 ++++++
 tb/tb_vending_machine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vending_machine_pkg.sv
// Shared types and default pricing for the coin-operated vend controller.
// No logic; imported by vending_machine.
package vending_machine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        VEND  = 2'd2
    } vend_state_t;

    localparam int DEFAULT_COIN_VALUE = 5;
    localparam int DEFAULT_PRICE      = 20;
    localparam int DEFAULT_CREDIT_W   = 8;

endpackage

// File: rtl/vending_machine.sv
// Coin credit accumulator; valid is a one-cycle vend pulse seen the cycle after the paying edge.
// Latency 0 cycles from registered state; no backpressure, coins are never refused.
module vending_machine
    import vending_machine_pkg::*;
#(
    parameter int COIN_VALUE = DEFAULT_COIN_VALUE,
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int CREDIT_W   = DEFAULT_CREDIT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic coin,
    output logic valid
);

    // Largest credit ever formed is (PRICE-1)+COIN_VALUE, so that must fit.
    if ((PRICE <= 0) || (COIN_VALUE <= 0) || (CREDIT_W < 1) || (CREDIT_W > 31) ||
        ((PRICE + COIN_VALUE - 1) >= (1 << CREDIT_W))) begin : g_bad_params
        $error("vending_machine: CREDIT_W too small for PRICE+COIN_VALUE-1");
    end

    localparam logic [CREDIT_W-1:0] COIN_C  = CREDIT_W'(COIN_VALUE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_t         state;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] sum;

    // Credit is already zero in IDLE and VEND, so one adder covers every state.
    assign sum   = credit + COIN_C;
    assign valid = (state == VEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            credit <= '0;
        end else begin
            case (state)
                IDLE, ACCUM, VEND: begin
                    if (coin) begin
                        if (sum >= PRICE_C) begin
                            state  <= VEND;
                            credit <= '0;
                        end else begin
                            state  <= ACCUM;
                            credit <= sum;
                        end
                    end else if (state == VEND) begin
                        state  <= IDLE;
                        credit <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    credit <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
`timescale 1ns/100ps
// Directed plus randomized checks of vending_machine against a credit-counting model.
module tb_vending_machine;
    import vending_machine_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic coin = 1'b0;
    logic coin2 = 1'b0;
    logic valid;
    logic valid2;

    int checks = 0;
    int errors = 0;

    // Model: credit in units; a vend happens when a coin lifts credit to PRICE or more.
    int m_credit [2];
    bit m_vend   [2];
    int m_price  [2] = '{20, 10};
    int m_coinv  [2] = '{5, 5};
    int vend_cnt;

    always #1 clk = ~clk;

    vending_machine dut (
        .clk   (clk),
        .reset (reset),
        .coin  (coin),
        .valid (valid)
    );

    vending_machine #(.COIN_VALUE(5), .PRICE(10), .CREDIT_W(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .coin  (coin2),
        .valid (valid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit c);
        if (c) begin
            if (m_credit[i] + m_coinv[i] >= m_price[i]) begin
                m_vend[i]   = 1'b1;
                m_credit[i] = 0;
            end else begin
                m_vend[i]   = 1'b0;
                m_credit[i] = m_credit[i] + m_coinv[i];
            end
        end else begin
            m_vend[i] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0;
            m_vend[i]   = 1'b0;
        end
    endtask

    // Called at a negedge: drive, take one rising edge, check at the next negedge.
    task automatic step(input bit c, input bit c2, input string tag);
        coin  = c;
        coin2 = c2;
        @(posedge clk);
        model_edge(0, c);
        model_edge(1, c2);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid), 32'(m_vend[0]));
        chk({tag, "_credit"}, 32'(dut.credit), 32'(m_credit[0]));
        chk({tag, "_valid2"}, 32'(valid2), 32'(m_vend[1]));
    endtask

    task automatic pulse_reset();
        coin  = 1'b0;
        coin2 = 1'b0;
        reset = 1'b1;
        model_reset();
        #0.5;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_credit", 32'(dut.credit), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #0.5;
        chk("por_valid", 32'(valid), 32'd0);
        chk("por_valid2", 32'(valid2), 32'd0);
        chk("por_credit", 32'(dut.credit), 32'd0);
        chk("por_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Coin held: vend on the 4th edge, then credit=5 after the 5th.
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, $sformatf("held%0d", k));
        chk("held_final_credit", 32'(dut.credit), 32'd5);
        pulse_reset();

        // Coin low forever: stays idle with zero credit.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, "nocoin");
        chk("nocoin_state", 32'(dut.state), 32'(IDLE));

        // Gapped coins: credit holds through gaps, vend after the 4th coin only.
        for (int k = 1; k <= 8; k++) step(k % 2 == 1, 1'b0, $sformatf("gap%0d", k));
        pulse_reset();

        // Three coins, reset, one coin: no vend, credit ends at 5.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "pre_rst");
        pulse_reset();
        step(1'b1, 1'b0, "post_rst");
        chk("post_rst_credit", 32'(dut.credit), 32'd5);
        step(1'b0, 1'b0, "post_rst_idle");

        // Async reset during VEND: valid must drop before the next edge.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "to_vend");
        chk("pre_async_valid", 32'(valid), 32'd1);
        coin = 1'b0;
        #0.2;
        reset = 1'b1;
        model_reset();
        #0.2;
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Low price instance: coin held vends every second edge.
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, $sformatf("p10_%0d", k));
        pulse_reset();

        // Random coins with occasional resets, both instances.
        vend_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            else begin
                step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, "rnd");
                if (m_vend[0]) vend_cnt++;
            end
        end
        chk("rnd_some_vends", 32'(vend_cnt > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
